// File: rtl/param_insertion_sorter.sv
// Burst insertion sorter: loads 1..DEPTH words over valid/ready, sorts them in place
// with one compare per cycle, then streams the sorted burst out with a last marker.
module param_insertion_sorter #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             descending,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    SORT_OUTER = 2'd1,
    SORT_INNER = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  // Storage is deliberately left out of reset; a reset simply abandons its contents.
  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] in_index_q, in_index_d;
  logic [CNT_W-1:0] out_index_q, out_index_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             desc_q, desc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             we0, we1;
  logic [IDX_W-1:0] waddr0, waddr1;
  logic [WIDTH-1:0] wdata0, wdata1;

  logic [IDX_W-1:0] i_idx;
  logic [CNT_W-1:0] out_index_inc;
  logic [IDX_W-1:0] out_nxt_idx;
  logic [WIDTH-1:0] cur_word;
  logic             cur_gt_key, cur_lt_key, cur_before_key;

  assign i_idx         = i_q[IDX_W-1:0];
  assign out_index_inc = out_index_q + CNT_W'(1);
  assign out_nxt_idx   = out_index_inc[IDX_W-1:0];
  assign cur_word      = mem[j_q];

  generate
    if (SIGNED) begin : g_signed_cmp
      assign cur_gt_key = $signed(cur_word) > $signed(key_q);
      assign cur_lt_key = $signed(cur_word) < $signed(key_q);
    end else begin : g_unsigned_cmp
      assign cur_gt_key = cur_word > key_q;
      assign cur_lt_key = cur_word < key_q;
    end
  endgenerate

  // Strict compare keeps equal keys in arrival order.
  assign cur_before_key = desc_q ? cur_lt_key : cur_gt_key;

  always_comb begin
    state_d     = state_q;
    in_index_d  = in_index_q;
    out_index_d = out_index_q;
    i_d         = i_q;
    j_d         = j_q;
    count_d     = count_q;
    key_d       = key_q;
    desc_d      = desc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    we0         = 1'b0;
    we1         = 1'b0;
    waddr0      = '0;
    waddr1      = '0;
    wdata0      = in_data;
    wdata1      = key_q;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          we0     = 1'b1;
          waddr0  = in_index_q[IDX_W-1:0];
          wdata0  = in_data;
          count_d = in_index_q + CNT_W'(1);
          if (in_index_q == '0) begin
            desc_d = descending;
          end
          if (in_last || (in_index_q == LAST_IDX)) begin
            in_index_d = '0;
            in_ready_d = 1'b0;
            if (in_index_q == '0) begin
              // A single word is already sorted: present it straight away.
              state_d     = DRAIN;
              out_index_d = '0;
              out_valid_d = 1'b1;
              out_data_d  = in_data;
              out_last_d  = 1'b1;
            end else begin
              state_d = SORT_OUTER;
              i_d     = CNT_W'(1);
            end
          end else begin
            in_index_d = in_index_q + CNT_W'(1);
          end
        end
      end

      SORT_OUTER: begin
        if (i_q == count_q) begin
          state_d     = DRAIN;
          out_index_d = '0;
          out_valid_d = 1'b1;
          out_data_d  = mem[0];
          out_last_d  = 1'b0;
        end else begin
          key_d   = mem[i_idx];
          j_d     = i_idx - IDX_W'(1);
          state_d = SORT_INNER;
        end
      end

      SORT_INNER: begin
        we0    = 1'b1;
        waddr0 = j_q + IDX_W'(1);
        if (cur_before_key) begin
          wdata0 = cur_word;
          if (j_q == '0) begin
            // Shift and final key placement land in the same cycle.
            we1     = 1'b1;
            waddr1  = '0;
            wdata1  = key_q;
            i_d     = i_q + CNT_W'(1);
            state_d = SORT_OUTER;
          end else begin
            j_d = j_q - IDX_W'(1);
          end
        end else begin
          wdata0  = key_q;
          i_d     = i_q + CNT_W'(1);
          state_d = SORT_OUTER;
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = LOAD;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            in_ready_d  = 1'b1;
            in_index_d  = '0;
            out_index_d = '0;
          end else begin
            out_index_d = out_index_inc;
            out_data_d  = mem[out_nxt_idx];
            out_last_d  = (out_index_inc == (count_q - CNT_W'(1)));
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase

    busy_d = (state_d != LOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      in_index_q  <= '0;
      out_index_q <= '0;
      i_q         <= '0;
      j_q         <= '0;
      count_q     <= '0;
      key_q       <= '0;
      desc_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_index_q  <= in_index_d;
      out_index_q <= out_index_d;
      i_q         <= i_d;
      j_q         <= j_d;
      count_q     <= count_d;
      key_q       <= key_d;
      desc_q      <= desc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) begin
      mem[waddr0] <= wdata0;
    end
    if (we1) begin
      mem[waddr1] <= wdata1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_param_insertion_sorter.sv
// Bench for param_insertion_sorter: a 32-bit unsigned sorter plus 8-bit signed and
// unsigned sorters fed the same stream, each checked against its own expected queue.
module tb_param_insertion_sorter;

  localparam int CW = $clog2(8 + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_last, descending, out_ready;
  logic [31:0] in_data;

  logic          in_ready0, out_valid0, out_last0, busy0, done0;
  logic [31:0]   out_data0;
  logic [CW-1:0] count0;
  logic          in_ready1, out_valid1, out_last1, busy1, done1;
  logic [7:0]    out_data1;
  logic [CW-1:0] count1;
  logic          in_ready2, out_valid2, out_last2, busy2, done2;
  logic [7:0]    out_data2;
  logic [CW-1:0] count2;

  param_insertion_sorter #(.WIDTH(32), .DEPTH(8), .SIGNED(1'b0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .descending(descending),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_last(out_last0), .count(count0), .busy(busy0), .done(done0)
  );

  param_insertion_sorter #(.WIDTH(8), .DEPTH(8), .SIGNED(1'b1)) u_dut_s8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data[7:0]), .in_last(in_last), .descending(descending),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_last(out_last1), .count(count1), .busy(busy1), .done(done1)
  );

  param_insertion_sorter #(.WIDTH(8), .DEPTH(8), .SIGNED(1'b0)) u_dut_u8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data[7:0]), .in_last(in_last), .descending(descending),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_last(out_last2), .count(count2), .busy(busy2), .done(done2)
  );

  logic [31:0]   o_data [3];
  logic          o_valid [3], o_last [3], o_done [3], o_rdy [3], o_busy [3];
  logic [CW-1:0] o_count [3];

  assign o_data[0] = out_data0;  assign o_data[1] = {24'd0, out_data1};  assign o_data[2] = {24'd0, out_data2};
  assign o_valid[0] = out_valid0; assign o_valid[1] = out_valid1; assign o_valid[2] = out_valid2;
  assign o_last[0] = out_last0;  assign o_last[1] = out_last1;  assign o_last[2] = out_last2;
  assign o_done[0] = done0;      assign o_done[1] = done1;      assign o_done[2] = done2;
  assign o_rdy[0] = in_ready0;   assign o_rdy[1] = in_ready1;   assign o_rdy[2] = in_ready2;
  assign o_busy[0] = busy0;      assign o_busy[1] = busy1;      assign o_busy[2] = busy2;
  assign o_count[0] = count0;    assign o_count[1] = count1;    assign o_count[2] = count2;

  typedef struct packed {
    logic [3:0]        n;
    logic              desc;
    logic              last8;
    logic [7:0]        lat;   // 255: latency not checked
    logic [7:0][31:0]  din;
    logic [7:0][31:0]  dexp;  // expected order for the 32-bit unsigned sorter
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  vec_t tv[$];
  exp_t q0[$], q1[$], q2[$];
  int   ta [8];
  int   te [8];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt [3];
  logic        prev_stall [3];
  logic [31:0] prev_data [3];
  logic        prev_last [3];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, required %0h", nm, d, act, req);
    end
  endtask

  task automatic add_vec(input int n, input bit desc, input bit last8, input int lat);
    vec_t v;
    v = '0;
    v.n = 4'(n); v.desc = desc; v.last8 = last8; v.lat = 8'(lat);
    for (int k = 0; k < 8; k++) begin
      v.din[k]  = 32'(ta[k]);
      v.dexp[k] = 32'(te[k]);
    end
    tv.push_back(v);
  endtask

  function automatic bit lt8(logic [7:0] a, logic [7:0] b, bit sgn);
    return sgn ? ($signed(a) < $signed(b)) : (a < b);
  endfunction

  // Rank-based stable reference for the 8-bit sorters.
  function automatic logic [31:0] model8(vec_t v, bit sgn, int pos);
    for (int e = 0; e < int'(v.n); e++) begin
      int r = 0;
      for (int f = 0; f < int'(v.n); f++) begin
        logic [7:0] a = v.din[f][7:0];
        logic [7:0] b = v.din[e][7:0];
        bit ahead;
        if (a == b) ahead = (f < e);
        else if (v.desc) ahead = lt8(b, a, sgn);
        else ahead = lt8(a, b, sgn);
        if (ahead) r++;
      end
      if (r == pos) return {24'd0, v.din[e][7:0]};
    end
    return 32'd0;
  endfunction

  function automatic int qsize(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int d, input exp_t x);
    case (d)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic qpop(input int d, output exp_t x);
    case (d)
      0: x = q0.pop_front();
      1: x = q1.pop_front();
      default: x = q2.pop_front();
    endcase
  endtask

  // Called at the falling edge: what is seen here is what the next rising edge transfers.
  task automatic mon();
    exp_t x;
    for (int d = 0; d < 3; d++) begin
      if (prev_stall[d]) begin
        chk("stall_valid", d, 32'(o_valid[d]), 32'd1);
        chk("stall_data", d, o_data[d], prev_data[d]);
        chk("stall_last", d, 32'(o_last[d]), 32'(prev_last[d]));
      end
      if (o_valid[d] && out_ready) begin
        if (qsize(d) == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_word dut%0d: got %0h, required no word", d, o_data[d]);
        end else begin
          qpop(d, x);
          $display("dut%0d out data=%0h last=%0b (want %0h/%0b)", d, o_data[d], o_last[d], x.data, x.last);
          chk("out_data", d, o_data[d], x.data);
          chk("out_last", d, 32'(o_last[d]), 32'(x.last));
        end
      end
      prev_stall[d] = o_valid[d] && !out_ready;
      prev_data[d]  = o_data[d];
      prev_last[d]  = o_last[d];
      if (o_done[d]) done_cnt[d]++;
    end
  endtask

  task automatic run_burst(input vec_t v, input bit stall, input bit poke);
    int k = 0, cyc = 0, c_end = -1, lat = -1, w = 0;
    int done_base [3];
    exp_t x;
    bit finished;
    while (!(o_rdy[0] && o_rdy[1] && o_rdy[2]) && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 200) chk("wait_in_ready", 0, 32'(o_rdy[0]), 32'd1);
    for (int e = 0; e < int'(v.n); e++) begin
      x.last = (e == int'(v.n) - 1);
      x.data = v.dexp[e];          qpush(0, x);
      x.data = model8(v, 1'b1, e); qpush(1, x);
      x.data = model8(v, 1'b0, e); qpush(2, x);
    end
    for (int d = 0; d < 3; d++) done_base[d] = done_cnt[d];
    $display("burst n=%0d desc=%0b stall=%0b", v.n, v.desc, stall);
    forever begin
      if (k < int'(v.n)) begin
        in_valid   = 1'b1;
        in_data    = v.din[k];
        in_last    = (k == int'(v.n) - 1) && ((v.n < 4'd8) || v.last8);
        descending = (k == 0) ? v.desc : !v.desc;
      end else begin
        in_valid   = poke && !o_rdy[0] && !o_rdy[1] && !o_rdy[2] && ($urandom_range(0, 2) == 0);
        in_data    = $urandom;
        in_last    = 1'($urandom_range(0, 1));
        descending = 1'($urandom_range(0, 1));
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      mon();
      if (k < int'(v.n) && in_valid && o_rdy[0]) begin
        if (k == int'(v.n) - 1) c_end = cyc;
        k++;
      end
      if (lat < 0 && c_end >= 0 && o_valid[0]) lat = cyc - 1 - c_end;
      finished = (k == int'(v.n));
      for (int d = 0; d < 3; d++)
        if (qsize(d) != 0 || done_cnt[d] == done_base[d]) finished = 1'b0;
      if (finished) break;
      if (cyc > 800) begin
        n_cmp++;
        n_fail++;
        $display("FAIL burst_timeout: got %0d words left, required 0", qsize(0) + qsize(1) + qsize(2));
        break;
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      chk("done_pulses", d, 32'(done_cnt[d] - done_base[d]), 32'd1);
      chk("count", d, 32'(o_count[d]), 32'(v.n));
    end
    if (v.lat != 8'hFF) chk("latency", 0, 32'(lat), 32'(v.lat));
    q0.delete(); q1.delete(); q2.delete();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    descending = 1'b0; out_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      done_cnt[d] = 0; prev_stall[d] = 1'b0; prev_data[d] = '0; prev_last[d] = 1'b0;
    end

    ta = '{5, 3, 8, 1, 9, 2, 7, 4};     te = '{1, 2, 3, 4, 5, 7, 8, 9};     add_vec(8, 0, 1, 255);
    te = '{9, 8, 7, 5, 4, 3, 2, 1};                                          add_vec(8, 1, 0, 255);
    te = '{1, 2, 3, 4, 5, 7, 8, 9};                                          add_vec(8, 0, 0, 255);
    ta = '{6, 6, 2, 0, 0, 0, 0, 0};     te = '{2, 6, 6, 0, 0, 0, 0, 0};     add_vec(3, 0, 0, 255);
    ta = '{42, 0, 0, 0, 0, 0, 0, 0};    te = '{42, 0, 0, 0, 0, 0, 0, 0};    add_vec(1, 0, 0, 0);
    ta = '{5, 251, 0, 128, 0, 0, 0, 0}; te = '{0, 5, 128, 251, 0, 0, 0, 0}; add_vec(4, 0, 0, 255);
    ta = '{1, 2, 3, 4, 5, 6, 7, 8};     te = '{1, 2, 3, 4, 5, 6, 7, 8};     add_vec(8, 0, 0, 15);
    ta = '{8, 7, 6, 5, 4, 3, 2, 1};                                          add_vec(8, 0, 0, 36);
    ta = '{100, 20, 300, 4, 50, 0, 0, 0}; te = '{300, 100, 50, 20, 4, 0, 0, 0}; add_vec(5, 1, 0, 255);
    ta = '{3, 1, 2, 0, 0, 0, 0, 0};     te = '{1, 2, 3, 0, 0, 0, 0, 0};     add_vec(3, 0, 0, 255);

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", d, 32'(o_rdy[d]), 32'd1);
      chk("rst_out_valid", d, 32'(o_valid[d]), 32'd0);
      chk("rst_out_last", d, 32'(o_last[d]), 32'd0);
      chk("rst_busy", d, 32'(o_busy[d]), 32'd0);
      chk("rst_done", d, 32'(o_done[d]), 32'd0);
      chk("rst_count", d, 32'(o_count[d]), 32'd0);
    end

    for (int i = 0; i < 9; i++) run_burst(tv[i], (i == 8), (i == 8));

    // Reverse-ordered burst, then reset while the inner loop is shifting.
    $display("burst n=8 reversed, reset mid-sort");
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = 32'(8 - k); in_last = 1'b0; descending = 1'b0;
      @(negedge clk); mon();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (10) begin
      @(negedge clk); mon();
      @(posedge clk); #1;
    end
    chk("busy_mid_sort", 0, 32'(busy0), 32'd1);
    chk("count_mid_sort", 0, 32'(count0), 32'd8);
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("async_rst_out_valid", d, 32'(o_valid[d]), 32'd0);
      chk("async_rst_out_last", d, 32'(o_last[d]), 32'd0);
      chk("async_rst_busy", d, 32'(o_busy[d]), 32'd0);
      chk("async_rst_done", d, 32'(o_done[d]), 32'd0);
      chk("async_rst_count", d, 32'(o_count[d]), 32'd0);
      chk("async_rst_in_ready", d, 32'(o_rdy[d]), 32'd1);
    end
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_burst(tv[9], 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
